// File: rtl/bpu_pkg.sv
// Branch-update types shared by the commit stage, the update queue and the predictor.
package bpu_pkg;

  typedef enum logic [1:0] {
    BR_COND = 2'b00,
    BR_JUMP = 2'b01,
    BR_CALL = 2'b10,
    BR_RET  = 2'b11
  } br_type_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    br_type_e    br_type;
    logic        taken;
    logic        mispred;
  } upd_entry_t;

  // Only conditional branches train the direction tables.
  function automatic logic trains_direction(input br_type_e t);
    return t == BR_COND;
  endfunction

endpackage

// File: rtl/bpu_update_queue.sv
// Dual-in / single-out queue of resolved branches feeding the predictor update channel.
// Optional zero-latency bypass into an empty queue: define BPU_UPDQ_BYPASS_EN.
module bpu_update_queue
  import bpu_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       in_valid,
  input  logic [31:0]      in_pc0,
  input  logic [31:0]      in_pc1,
  input  logic [31:0]      in_target0,
  input  logic [31:0]      in_target1,
  input  logic [1:0]       in_type0,
  input  logic [1:0]       in_type1,
  input  logic             in_taken0,
  input  logic             in_taken1,
  input  logic             in_mispred0,
  input  logic             in_mispred1,
  output logic             in_ready,
  output logic             branch_mistaken,
  output logic [31:0]      wrong_pc,
  output logic [31:0]      right_target,
  output logic [1:0]       ins_type_w,
  output logic             update_orien_en,
  output logic [31:0]      retire_pc,
  output logic             right_orien,
  output logic [CNT_W-1:0] occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  upd_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count, npush;
  logic             pop;
  logic             bypass_ok;

  upd_entry_t lane0, lane1, wr_d0, wr_d1, byp, out_e;
  logic       wr0, wr1, byp_valid, out_v;

  assign in_ready  = (count <= CNT_W'(DEPTH - 2));
  assign pop       = (count != '0);
  assign occupancy = count;

`ifdef BPU_UPDQ_BYPASS_EN
  assign bypass_ok = (count == '0);
`else
  assign bypass_ok = 1'b0;
`endif

  // Lanes are compacted so the oldest accepted branch always lands at wptr.
  always_comb begin
    lane0 = '{pc: in_pc0, target: in_target0, br_type: br_type_e'(in_type0),
              taken: in_taken0, mispred: in_mispred0};
    lane1 = '{pc: in_pc1, target: in_target1, br_type: br_type_e'(in_type1),
              taken: in_taken1, mispred: in_mispred1};
    wr0       = 1'b0;
    wr1       = 1'b0;
    wr_d0     = lane0;
    wr_d1     = lane1;
    byp_valid = 1'b0;
    byp       = lane0;
    if (in_ready) begin
      if (bypass_ok && in_valid != 2'b00) begin
        byp_valid = 1'b1;
        if (in_valid[0]) begin
          byp = lane0;
          if (in_valid[1]) begin
            wr0   = 1'b1;
            wr_d0 = lane1;
          end
        end else begin
          byp = lane1;
        end
      end else begin
        wr0   = |in_valid;
        wr_d0 = in_valid[0] ? lane0 : lane1;
        wr1   = &in_valid;
      end
    end
  end

  assign npush = CNT_W'(wr0) + CNT_W'(wr1);

  always_ff @(posedge clk) begin
    if (wr0) mem[wptr] <= wr_d0;
    if (wr1) mem[wptr + PTR_W'(1)] <= wr_d1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PTR_W'(npush);
      rptr  <= rptr + PTR_W'(pop);
      count <= count + npush - CNT_W'(pop);
    end
  end

  always_comb begin
    out_e = '0;
    out_v = 1'b0;
    if (pop) begin
      out_e = mem[rptr];
      out_v = 1'b1;
    end else if (byp_valid) begin
      out_e = byp;
      out_v = 1'b1;
    end
    branch_mistaken = out_v & out_e.mispred;
    wrong_pc        = out_e.pc;
    retire_pc       = out_e.pc;
    right_target    = out_e.target;
    ins_type_w      = out_e.br_type;
    right_orien     = out_v & out_e.taken;
    update_orien_en = out_v & trains_direction(out_e.br_type);
  end

endmodule
